// File: rtl/first_system_stream_if.sv
// Handshake and data bundle for first_system_stream.
// The master drives operands and out_ready; the slave returns results, occupancy and the transfer count.
interface first_system_stream_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in1;
    logic [WIDTH-1:0]         in2;
    logic [1:0]               mode;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out1;
    logic [WIDTH-1:0]         out2;
    logic [$clog2(DEPTH):0]   level;
    logic [CNT_W-1:0]         xfer_cnt;

    modport master (
        output in_valid, in1, in2, mode, out_ready,
        input  in_ready, out_valid, out1, out2, level, xfer_cnt
    );

    modport slave (
        input  in_valid, in1, in2, mode, out_ready,
        output in_ready, out_valid, out1, out2, level, xfer_cnt
    );
endinterface

// File: rtl/first_system_stream.sv
// Operand-pair stream processor: a mode-selected bitwise/add function whose results queue
// in a DEPTH-entry circular FIFO, giving one cycle of latency and a saturating transfer count.
module first_system_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    first_system_stream_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [2*WIDTH-1:0] calc_result(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       m
    );
        logic [WIDTH:0]       sum;
        logic [2*WIDTH-1:0]   res;
        sum = {1'b0, a} + {1'b0, b};
        case (m)
            2'b00:   res = {(a & b) ^ (a | b), ~b};
            2'b01:   res = {a & b, a | b};
            2'b10:   res = {~(a ^ b), ~a};
            2'b11:   res = {sum[WIDTH-1:0], WIDTH'(sum[WIDTH])};
            default: res = {(2*WIDTH){1'b0}};
        endcase
        return res;
    endfunction

    logic [2*WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [CNT_W-1:0]   r_xfer_cnt;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_push;
    logic               w_pop;
    logic [2*WIDTH-1:0] w_result;
    logic [2*WIDTH-1:0] w_head;

    // Handshake qualification; in_ready deliberately ignores out_ready so a full FIFO never accepts.
    always_comb begin
        w_in_ready  = rst_n && (r_level != LVL_FULL);
        w_out_valid = rst_n && (r_level != LVL_ZERO);
        w_push      = bus.in_valid && w_in_ready;
        w_pop       = w_out_valid && bus.out_ready;
        w_result    = calc_result(bus.in1, bus.in2, bus.mode);
        if (w_out_valid) begin
            w_head = r_mem[r_rd_ptr];
        end else begin
            w_head = {(2*WIDTH){1'b0}};
        end
    end

    // Result storage; entries are only observable through level, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_result;
        end
    end

    // Pointers, occupancy and the saturating transfer counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_level    <= LVL_ZERO;
            r_xfer_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_ONE;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_ONE;
            end
            if (w_pop && (r_xfer_cnt != CNT_MAX)) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_ONE;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out1      = w_head[2*WIDTH-1:WIDTH];
    assign bus.out2      = w_head[WIDTH-1:0];
    assign bus.level     = r_level;
    assign bus.xfer_cnt  = r_xfer_cnt;
endmodule
